// File: rtl/load_store_unit_if.sv
// Data-memory port between the load/store unit and memory: one request
// channel (valid/ready) and one read-response channel (valid only).
// Latency: none, wires only. Backpressure: memory holds off requests with
// LSU_Mem_Req_Ready; responses cannot be backpressured.
//
// Ports (master = LSU side):
//   LSU_Mem_Req_Valid / LSU_Mem_Req_Ready : request handshake
//   LSU_Mem_Addr_OutBUS                   : word-aligned address
//   LSU_Mem_Write                         : 1 = write, 0 = read
//   LSU_Mem_ByteEn_OutBUS                 : byte-lane enables
//   LSU_Mem_WData_OutBUS                  : lane-replicated store data
//   LSU_Mem_Resp_Valid / LSU_Mem_RData_InBUS : read response
interface load_store_unit_if;
  logic        LSU_Mem_Req_Valid;
  logic        LSU_Mem_Req_Ready;
  logic [31:0] LSU_Mem_Addr_OutBUS;
  logic        LSU_Mem_Write;
  logic [3:0]  LSU_Mem_ByteEn_OutBUS;
  logic [31:0] LSU_Mem_WData_OutBUS;
  logic        LSU_Mem_Resp_Valid;
  logic [31:0] LSU_Mem_RData_InBUS;

  modport master (
    output LSU_Mem_Req_Valid, LSU_Mem_Addr_OutBUS, LSU_Mem_Write,
           LSU_Mem_ByteEn_OutBUS, LSU_Mem_WData_OutBUS,
    input  LSU_Mem_Req_Ready, LSU_Mem_Resp_Valid, LSU_Mem_RData_InBUS
  );

  modport slave (
    input  LSU_Mem_Req_Valid, LSU_Mem_Addr_OutBUS, LSU_Mem_Write,
           LSU_Mem_ByteEn_OutBUS, LSU_Mem_WData_OutBUS,
    output LSU_Mem_Req_Ready, LSU_Mem_Resp_Valid, LSU_Mem_RData_InBUS
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one memory transaction per load/store, lane steering,
// byte enables and load sign/zero extension.
// Latency: store Done 2 cycles after request, load 3 cycles (zero-wait memory).
// Backpressure: request held until Ready; pipeline stalled until completion;
// accesses abort with Error after TIMEOUT_CYCLES in REQ/WAIT_RESP (0 = never).
//
// Ports:
//   LSU_CLOCK_50, LSU_RESET_InHigh : clock, synchronous active-high reset
//   LSU_En_In, LSU_DataMem_Read_In, LSU_DataMem_Write_In : control-unit strobes
//   LSU_Funct3_InBUS, LSU_Addr_InBUS, LSU_StoreData_InBUS : access descriptor
//   mem                            : data-memory port (master side)
//   LSU_Stall, LSU_Done, LSU_Error : pipeline control / status pulses
//   LSU_LoadData_OutBUS            : extended load result, held between loads
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              LSU_CLOCK_50,
  input  logic              LSU_RESET_InHigh,
  input  logic              LSU_En_In,
  input  logic              LSU_DataMem_Read_In,
  input  logic              LSU_DataMem_Write_In,
  input  logic [2:0]        LSU_Funct3_InBUS,
  input  logic [31:0]       LSU_Addr_InBUS,
  input  logic [31:0]       LSU_StoreData_InBUS,
  load_store_unit_if.master mem,
  output logic              LSU_Stall,
  output logic              LSU_Done,
  output logic [31:0]       LSU_LoadData_OutBUS,
  output logic              LSU_Error
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Last counter value at which the access may still complete.
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          req_valid_q;
  logic          stall_q;
  logic          done_q;
  logic          err_q;
  logic [29:0]   addr_q;
  logic [1:0]    lane_q;
  logic [2:0]    f3_q;
  logic          write_q;
  logic [3:0]    byteen_q;
  logic [31:0]   wdata_q;
  logic [31:0]   load_q;

  logic        req_vld;
  logic        illegal;
  logic        take_ok;
  logic        take_bad;
  logic        timeout_hit;
  logic [3:0]  byteen_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;

  // Exactly one of read/write must accompany the enable.
  assign req_vld = LSU_En_In & (LSU_DataMem_Read_In ^ LSU_DataMem_Write_In);

  // funct3 011/11x never legal; unsigned variants (1xx) are load-only.
  assign illegal =
      (LSU_Funct3_InBUS == 3'b011)
    | (LSU_Funct3_InBUS[2] & LSU_Funct3_InBUS[1])
    | (LSU_DataMem_Write_In & LSU_Funct3_InBUS[2])
    | ((LSU_Funct3_InBUS[1:0] == 2'b01) & LSU_Addr_InBUS[0])
    | ((LSU_Funct3_InBUS[1:0] == 2'b10) & (|LSU_Addr_InBUS[1:0]));

  assign take_ok  = (state_q == IDLE) & req_vld & ~illegal;
  assign take_bad = (state_q == IDLE) & req_vld &  illegal;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q >= TO_LAST);

  always_comb begin
    byteen_nxt = 4'b1111;
    wdata_nxt  = 32'h0;
    case (LSU_Funct3_InBUS[1:0])
      2'b00:   byteen_nxt = 4'b0001 << LSU_Addr_InBUS[1:0];
      2'b01:   byteen_nxt = 4'b0011 << {LSU_Addr_InBUS[1], 1'b0};
      default: byteen_nxt = 4'b1111;
    endcase
    if (LSU_DataMem_Write_In) begin
      case (LSU_Funct3_InBUS[1:0])
        2'b00:   wdata_nxt = {4{LSU_StoreData_InBUS[7:0]}};
        2'b01:   wdata_nxt = {2{LSU_StoreData_InBUS[15:0]}};
        default: wdata_nxt = LSU_StoreData_InBUS;
      endcase
    end
  end

  // Bring the addressed lane down to bit 0, then extend per funct3.
  assign rd_shift = mem.LSU_Mem_RData_InBUS >> {lane_q, 3'b000};

  always_comb begin
    load_ext = rd_shift;
    case (f3_q)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_ext = {24'h0, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  load_ext = {16'h0, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  always_ff @(posedge LSU_CLOCK_50) begin
    if (LSU_RESET_InHigh) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      stall_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      lane_q      <= '0;
      f3_q        <= '0;
      write_q     <= 1'b0;
      byteen_q    <= '0;
      wdata_q     <= '0;
      load_q      <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (take_ok) begin
            addr_q      <= LSU_Addr_InBUS[31:2];
            lane_q      <= LSU_Addr_InBUS[1:0];
            f3_q        <= LSU_Funct3_InBUS;
            write_q     <= LSU_DataMem_Write_In;
            byteen_q    <= byteen_nxt;
            wdata_q     <= wdata_nxt;
            req_valid_q <= 1'b1;
            stall_q     <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 1'b1;
          // Acceptance wins over a coincident timeout.
          if (mem.LSU_Mem_Req_Ready) begin
            req_valid_q <= 1'b0;
            if (write_q) begin
              stall_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= WAIT_RESP;
            end
          end else if (timeout_hit) begin
            req_valid_q <= 1'b0;
            stall_q     <= 1'b0;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            state_q     <= IDLE;
          end
        end
        WAIT_RESP: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem.LSU_Mem_Resp_Valid) begin
            load_q  <= load_ext;
            stall_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (timeout_hit) begin
            stall_q <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          // DONE: pipeline advances this cycle; next request seen in IDLE.
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem.LSU_Mem_Req_Valid     = req_valid_q;
  assign mem.LSU_Mem_Addr_OutBUS   = {addr_q, 2'b00};
  assign mem.LSU_Mem_Write         = write_q;
  assign mem.LSU_Mem_ByteEn_OutBUS = byteen_q;
  assign mem.LSU_Mem_WData_OutBUS  = wdata_q;

  // Illegal requests complete in the cycle they are presented.
  assign LSU_Stall           = stall_q | take_ok;
  assign LSU_Done            = done_q | take_bad;
  assign LSU_Error           = err_q | take_bad;
  assign LSU_LoadData_OutBUS = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rd;
  logic        wr;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] sdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] ldata;

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit_if mem_if ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .LSU_CLOCK_50         (clk),
    .LSU_RESET_InHigh     (rst),
    .LSU_En_In            (en),
    .LSU_DataMem_Read_In  (rd),
    .LSU_DataMem_Write_In (wr),
    .LSU_Funct3_InBUS     (f3),
    .LSU_Addr_InBUS       (addr),
    .LSU_StoreData_InBUS  (sdata),
    .mem                  (mem_if.master),
    .LSU_Stall            (stall),
    .LSU_Done             (done),
    .LSU_LoadData_OutBUS  (ldata),
    .LSU_Error            (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait load: request cycle 0, REQ cycle 1, WAIT cycle 2, DONE cycle 3.
  task automatic load_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [3:0] be,
                         input logic [31:0] exp);
    en = 1; rd = 1; wr = 0; f3 = fn; addr = a; #1;
    chk({tag, ".c0_stall"}, 32'(stall), 32'd1);
    chk({tag, ".c0_done"}, 32'(done), 32'd0);
    step(); en = 0; rd = 0; mem_if.LSU_Mem_Req_Ready = 1; #1;
    chk({tag, ".c1_reqv"}, 32'(mem_if.LSU_Mem_Req_Valid), 32'd1);
    chk({tag, ".c1_addr"}, mem_if.LSU_Mem_Addr_OutBUS, {a[31:2], 2'b00});
    chk({tag, ".c1_be"}, 32'(mem_if.LSU_Mem_ByteEn_OutBUS), 32'(be));
    chk({tag, ".c1_write"}, 32'(mem_if.LSU_Mem_Write), 32'd0);
    chk({tag, ".c1_wdata"}, mem_if.LSU_Mem_WData_OutBUS, 32'h0);
    chk({tag, ".c1_stall"}, 32'(stall), 32'd1);
    step(); mem_if.LSU_Mem_Req_Ready = 0;
    mem_if.LSU_Mem_Resp_Valid = 1; mem_if.LSU_Mem_RData_InBUS = rdata; #1;
    chk({tag, ".c2_reqv"}, 32'(mem_if.LSU_Mem_Req_Valid), 32'd0);
    chk({tag, ".c2_stall"}, 32'(stall), 32'd1);
    chk({tag, ".c2_done"}, 32'(done), 32'd0);
    step(); mem_if.LSU_Mem_Resp_Valid = 0; #1;
    chk({tag, ".c3_done"}, 32'(done), 32'd1);
    chk({tag, ".c3_stall"}, 32'(stall), 32'd0);
    chk({tag, ".c3_err"}, 32'(err), 32'd0);
    chk({tag, ".c3_ldata"}, ldata, exp);
    step(); #1;
    chk({tag, ".c4_done"}, 32'(done), 32'd0);
    chk({tag, ".c4_ldata"}, ldata, exp);
  endtask

  // Store with Ready withheld for 'dly' REQ cycles.
  task automatic store_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] d, input int dly, input logic [3:0] be,
                          input logic [31:0] wd);
    en = 1; rd = 0; wr = 1; f3 = fn; addr = a; sdata = d; #1;
    chk({tag, ".c0_stall"}, 32'(stall), 32'd1);
    step(); en = 0; wr = 0; sdata = 32'h0;
    for (int i = 0; i <= dly; i++) begin
      mem_if.LSU_Mem_Req_Ready = (i == dly); #1;
      chk({tag, ".reqv"}, 32'(mem_if.LSU_Mem_Req_Valid), 32'd1);
      chk({tag, ".addr"}, mem_if.LSU_Mem_Addr_OutBUS, {a[31:2], 2'b00});
      chk({tag, ".be"}, 32'(mem_if.LSU_Mem_ByteEn_OutBUS), 32'(be));
      chk({tag, ".wdata"}, mem_if.LSU_Mem_WData_OutBUS, wd);
      chk({tag, ".write"}, 32'(mem_if.LSU_Mem_Write), 32'd1);
      chk({tag, ".stall"}, 32'(stall), 32'd1);
      chk({tag, ".done_early"}, 32'(done), 32'd0);
      step();
    end
    mem_if.LSU_Mem_Req_Ready = 0; #1;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".done_stall"}, 32'(stall), 32'd0);
    chk({tag, ".done_reqv"}, 32'(mem_if.LSU_Mem_Req_Valid), 32'd0);
    chk({tag, ".done_err"}, 32'(err), 32'd0);
    step(); #1;
    chk({tag, ".after_done"}, 32'(done), 32'd0);
  endtask

  // Illegal request: Error+Done in the presentation cycle, no memory traffic.
  task automatic illegal_op(input string tag, input logic r, input logic w,
                            input logic [2:0] fn, input logic [31:0] a,
                            input logic [31:0] keep_ld);
    en = 1; rd = r; wr = w; f3 = fn; addr = a; #1;
    chk({tag, ".err"}, 32'(err), 32'd1);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    chk({tag, ".reqv0"}, 32'(mem_if.LSU_Mem_Req_Valid), 32'd0);
    step(); en = 0; rd = 0; wr = 0; #1;
    chk({tag, ".reqv1"}, 32'(mem_if.LSU_Mem_Req_Valid), 32'd0);
    chk({tag, ".err1"}, 32'(err), 32'd0);
    chk({tag, ".done1"}, 32'(done), 32'd0);
    chk({tag, ".ldata"}, ldata, keep_ld);
  endtask

  initial begin
    rst = 1; en = 0; rd = 0; wr = 0; f3 = 3'b000; addr = 32'h0; sdata = 32'h0;
    mem_if.LSU_Mem_Req_Ready  = 0;
    mem_if.LSU_Mem_Resp_Valid = 0;
    mem_if.LSU_Mem_RData_InBUS = 32'h0;
    step(); step();
    rst = 0; #1;
    chk("rst.reqv", 32'(mem_if.LSU_Mem_Req_Valid), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.ldata", ldata, 32'h0);
    chk("rst.be", 32'(mem_if.LSU_Mem_ByteEn_OutBUS), 32'h0);
    chk("rst.wdata", mem_if.LSU_Mem_WData_OutBUS, 32'h0);
    chk("rst.addr", mem_if.LSU_Mem_Addr_OutBUS, 32'h0);
    step();

    load_op("lw100",  3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    load_op("lb103",  3'b000, 32'h0000_0103, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
    load_op("lbu103", 3'b100, 32'h0000_0103, 32'h80FF_0000, 4'b1000, 32'h0000_0080);
    load_op("lhu102", 3'b101, 32'h0000_0102, 32'h80FF_0000, 4'b1100, 32'h0000_80FF);
    load_op("lh102",  3'b001, 32'h0000_0102, 32'h80FF_0000, 4'b1100, 32'hFFFF_80FF);
    load_op("lb101",  3'b000, 32'h0000_0101, 32'h1234_5678, 4'b0010, 32'h0000_0056);

    // Ready arrives on the last REQ cycle before the 4-cycle timeout.
    store_op("sh206", 3'b001, 32'h0000_0206, 32'h1234_ABCD, 3, 4'b1100, 32'hABCD_ABCD);
    store_op("sb001", 3'b000, 32'h0000_0001, 32'h0000_00EF, 0, 4'b0010, 32'hEFEF_EFEF);
    store_op("sw008", 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 0, 4'b1111, 32'hCAFE_F00D);

    illegal_op("lw_mis",  1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0000_0056);
    illegal_op("f3_011",  1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0000_0056);
    illegal_op("lh_mis",  1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0000_0056);
    illegal_op("sbu_st",  1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0000_0056);

    // Both strobes set: ignored, no stall, no pulses.
    en = 1; rd = 1; wr = 1; f3 = 3'b010; addr = 32'h100; #1;
    chk("both.stall", 32'(stall), 32'd0);
    chk("both.done", 32'(done), 32'd0);
    chk("both.err", 32'(err), 32'd0);
    step(); en = 0; rd = 0; wr = 0; #1;
    chk("both.reqv", 32'(mem_if.LSU_Mem_Req_Valid), 32'd0);

    // Timeout: Ready held low, 4 REQ cycles then abort.
    en = 1; rd = 1; f3 = 3'b010; addr = 32'h0000_0200; #1;
    chk("to.c0_stall", 32'(stall), 32'd1);
    step(); en = 0; rd = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to.reqv", 32'(mem_if.LSU_Mem_Req_Valid), 32'd1);
      chk("to.err_early", 32'(err), 32'd0);
      step();
    end
    #1;
    chk("to.reqv_drop", 32'(mem_if.LSU_Mem_Req_Valid), 32'd0);
    chk("to.err", 32'(err), 32'd1);
    chk("to.done", 32'(done), 32'd1);
    chk("to.stall", 32'(stall), 32'd0);
    chk("to.ldata", ldata, 32'h0000_0056);
    step(); #1;
    chk("to.err_clr", 32'(err), 32'd0);
    chk("to.done_clr", 32'(done), 32'd0);
    load_op("after_to", 3'b010, 32'h0000_0204, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);

    // Reset while waiting for a response; the late response is dropped.
    en = 1; rd = 1; f3 = 3'b010; addr = 32'h0000_0300; mem_if.LSU_Mem_Req_Ready = 1; #1;
    step(); en = 0; rd = 0;
    step(); mem_if.LSU_Mem_Req_Ready = 0; rst = 1;
    step(); rst = 0;
    mem_if.LSU_Mem_Resp_Valid = 1; mem_if.LSU_Mem_RData_InBUS = 32'h1122_3344; #1;
    chk("mrst.reqv", 32'(mem_if.LSU_Mem_Req_Valid), 32'd0);
    chk("mrst.stall", 32'(stall), 32'd0);
    chk("mrst.done", 32'(done), 32'd0);
    chk("mrst.ldata", ldata, 32'h0);
    step(); mem_if.LSU_Mem_Resp_Valid = 0; #1;
    chk("mrst.done2", 32'(done), 32'd0);
    chk("mrst.ldata2", ldata, 32'h0);
    chk("mrst.be", 32'(mem_if.LSU_Mem_ByteEn_OutBUS), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the main control unit.
- Consumes the control unit's LSU enable and data-memory read/write strobes, plus funct3, the ALU-computed effective address and rs2 store data.
- Runs one valid/ready transaction per load/store on the data-memory port: byte-lane steering, byte enables, load sign/zero extension.
- Stalls the core pipeline until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ plus WAIT_RESP before the access is aborted with an error; 0 disables the timeout.

Ports:
- LSU_CLOCK_50  in  1  core clock; all state changes on the rising edge.
- LSU_RESET_InHigh  in  1  reset, synchronous, active-high.
- LSU_En_In  in  1  from control unit: instruction is a load/store.
- LSU_DataMem_Read_In  in  1  from control unit: load.
- LSU_DataMem_Write_In  in  1  from control unit: store.
- LSU_Funct3_InBUS  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; SB/SH/SW use 000/001/010.
- LSU_Addr_InBUS  in  32  effective address from the ALU.
- LSU_StoreData_InBUS  in  32  rs2 value.
- LSU_Mem_Req_Valid  out  1  memory request valid.
- LSU_Mem_Req_Ready  in  1  memory accepts the request.
- LSU_Mem_Addr_OutBUS  out  32  word-aligned address, {addr[31:2],2'b00}.
- LSU_Mem_Write  out  1  1 = write, 0 = read.
- LSU_Mem_ByteEn_OutBUS  out  4  byte lane enables.
- LSU_Mem_WData_OutBUS  out  32  lane-replicated store data.
- LSU_Mem_Resp_Valid  in  1  read data valid.
- LSU_Mem_RData_InBUS  in  32  read data word.
- LSU_Stall  out  1  hold the pipeline.
- LSU_Done  out  1  one-cycle completion pulse.
- LSU_LoadData_OutBUS  out  32  extended load result, held until the next load completes.
- LSU_Error  out  1  one-cycle pulse: misaligned address, illegal funct3, or timeout.

Behaviour:
- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- Reset: state IDLE, counter 0; all outputs 0, including Req_Valid, Stall, Done, Error, LoadData, ByteEn and WData.
- A request is valid when En=1 and exactly one of Read/Write is 1. En=1 with Read=Write=0 or both 1 is ignored; the FSM stays in IDLE.

IDLE, on a valid request:
- Check alignment and funct3 combinationally. Halfword with addr[0]=1, word with addr[1:0]!=00, or funct3 in {011,110,111} (and 100/101 on stores) means illegal.
- Illegal: Error=1 for 1 cycle, Done=1 same cycle, Stall=0, no memory request, LoadData unchanged.
- Legal: capture addr, funct3, direction, ByteEn and WData into registers; go to REQ. Stall=1 combinationally in this same cycle.

Store lane steering:
- SB: WData={4{d[7:0]}}, ByteEn=0001<<addr[1:0].
- SH: WData={2{d[15:0]}}, ByteEn=0011<<{addr[1],0}.
- SW: WData=d, ByteEn=1111.
- Loads drive ByteEn with the same pattern and WData=0.

REQ:
- Req_Valid=1. Addr, Write, ByteEn and WData are held stable until Ready.
- On Ready=1: a store goes to DONE; a load goes to WAIT_RESP.
- Req_Valid must never deassert before Ready.

WAIT_RESP:
- On Resp_Valid=1, extract the lane selected by addr[1:0]:
  - LB sign-extends bit 7; LBU zero-extends.
  - LH/LHU select the half by addr[1] and extend from bit 15.
  - LW passes the word through.
- Register the result into LoadData and go to DONE.
- Resp_Valid is ignored in every other state.

DONE:
- Done=1, Stall=0 for exactly one cycle; return to IDLE.
- The pipeline advances on this cycle; a new request is sampled in IDLE on the following cycle.

Stall and latency:
- Stall=1 in REQ and WAIT_RESP, and in IDLE on a legal request.
- Minimum latency (Ready and Resp same cycle as entry): store has Done 2 cycles after the request is presented; load 3 cycles.

Timeout:
- The counter increments every cycle in REQ/WAIT_RESP and clears in IDLE.
- When it reaches TIMEOUT_CYCLES, drop Req_Valid, pulse Error and Done, go to IDLE; LoadData is unchanged.

Reset mid-operation:
- Immediate return to IDLE with Req_Valid=0. A later stale Resp_Valid is ignored.

Test Plan:
- LW addr 0x100 with Ready=1 and Resp in the first WAIT cycle, RData 0xDEADBEEF -> Mem_Addr 0x100, ByteEn 1111, LoadData 0xDEADBEEF, Done at cycle 3, Stall high for cycles 0-2.
- LB addr 0x103, RData 0x80FF_0000 -> LoadData 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- SH addr 0x206, data 0x1234ABCD, Ready delayed 3 cycles -> Req_Valid and Mem fields stable 3 cycles, ByteEn 1100, WData 0xABCDABCD, Mem_Addr 0x204, Done after accept.
- LW addr 0x102 -> Error and Done pulse same cycle, Req_Valid never asserted, Stall 0; funct3 011 -> same.
- TIMEOUT_CYCLES=4, Ready held 0 -> Req_Valid drops and Error pulses after 4 cycles in REQ; FSM back in IDLE.
- Reset asserted in WAIT_RESP, then Resp_Valid=1 -> outputs 0, LoadData 0, no Done.
